// File: rtl/hexview_pkg.sv
// hexview_pkg: shared 4x7 hex font and default colours for the hex digit viewer.
package hexview_pkg;
   localparam logic [11:0] FG_DEF = 12'h00f;
   localparam logic [11:0] BG_DEF = 12'hfff;
   localparam logic [11:0] HL_DEF = 12'hf00;
   // one nibble per glyph row, row 0 in the top nibble, column 0 = nibble MSB
   localparam logic [27:0] FONT [16] = '{
      28'hF99999F, 28'h1111111, 28'hF11F88F, 28'hF11F11F,
      28'h999F111, 28'hF88F11F, 28'hF88F99F, 28'hF111111,
      28'hF99F99F, 28'hF99F11F, 28'h00E1797, 28'h88E999E,
      28'h0078887, 28'h1179997, 28'h0069F87, 28'h344E444
   };
   function automatic logic [3:0] glyph_row(input logic [3:0] nib, input logic [2:0] row);
      logic [27:0] g;
      g = FONT[nib];
      return row > 3'd6 ? 4'd0 : g[5'd24 - {row, 2'b00} +: 4];
   endfunction
endpackage

// File: rtl/hex_font_rom.sv
// hex_font_rom: combinational glyph lookup, nibble and row -> 4 row bits.
module hex_font_rom import hexview_pkg::*; (
   input  logic [3:0] nibble,
   input  logic [2:0] row,
   output logic [3:0] bits
);
   assign bits = glyph_row(nibble, row);
endmodule

// File: rtl/page_hexview.sv
// page_hexview: editable row of hex digits rendered onto a VGA raster.
// Buttons step individual nibbles on release; pixels come out two clocks after x/y.
module page_hexview import hexview_pkg::*; #(
   parameter int          DIGITS = 16,
   parameter int          SCALE  = 8,
   parameter int          X0     = 0,
   parameter int          Y0     = 120,
   parameter logic [63:0] INIT   = 64'h1145141919810893,
   parameter logic [11:0] FG     = FG_DEF,
   parameter logic [11:0] BG     = BG_DEF,
   parameter logic [11:0] HL     = HL_DEF
) (
   input  logic                  vga_clk,
   input  logic                  vga_rst,
   input  logic [9:0]            x_pos,
   input  logic [9:0]            y_pos,
   input  logic [DIGITS-1:0]     btns,
   input  logic                  mode_dec,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   output logic [4*DIGITS-1:0]   value,
   output logic [11:0]           pixel_data
);
   localparam int W  = 4*DIGITS;
   localparam int CW = 5*SCALE;
   localparam int SH = $clog2(SCALE);
   logic [DIGITS-1:0] s1_q, s1_d, s2_q, s2_d, s3_q, s3_d, rel;
   logic [W-1:0]      value_q, value_d;
   logic              in_q, in_d;
   logic [3:0]        dig_q, dig_d, idx, nib, bits;
   logic [2:0]        row_q, row_d;
   logic [1:0]        col_q, col_d;
   logic [11:0]       pix_q, pix_d;
   logic              hl;
   int                xr, yr, off;

   always_comb begin
      s1_d = btns;
      s2_d = s1_q;
      s3_d = s2_q;
      rel = s3_q & ~s2_q;
      value_d = value_q;
      for (int j = 0; j < DIGITS; j++)
         if (rel[j]) value_d[4*j +: 4] = mode_dec ? value_q[4*j +: 4] - 4'd1 : value_q[4*j +: 4] + 4'd1;
      if (load) value_d = load_val;
   end

   // stage 1: locate the pixel inside the digit row by constant division
   always_comb begin
      xr = int'(x_pos) - X0;
      yr = int'(y_pos) - Y0;
      off = xr % CW;
      dig_d = 4'(xr / CW);
      row_d = 3'(yr >>> SH);
      col_d = 2'((off - SCALE/2) >>> SH);
      in_d = xr >= 0 && xr < DIGITS*CW && yr >= 0 && yr < 7*SCALE &&
             off >= SCALE/2 && off < SCALE/2 + 4*SCALE;
   end

   // stage 2: digit i shows the nibble counted from the top, edited by button DIGITS-1-i
   always_comb begin
      idx = 4'(DIGITS-1) - dig_q;
      nib = value_q[{idx, 2'b00} +: 4];
      hl = s2_q[idx];
      pix_d = in_q && bits[~col_q] ? (hl ? HL : FG) : BG;
   end

   hex_font_rom u_rom (.nibble(nib), .row(row_q), .bits(bits));

   always_ff @(posedge vga_clk or posedge vga_rst)
      if (vga_rst) begin
         s1_q <= '0;
         s2_q <= '0;
         s3_q <= '0;
         value_q <= INIT[W-1:0];
         in_q <= 1'b0;
         dig_q <= '0;
         row_q <= '0;
         col_q <= '0;
         pix_q <= '0;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
         s3_q <= s3_d;
         value_q <= value_d;
         in_q <= in_d;
         dig_q <= dig_d;
         row_q <= row_d;
         col_q <= col_d;
         pix_q <= pix_d;
      end

   assign value = value_q;
   assign pixel_data = pix_q;
endmodule
